seq_mult_ctrl: RTL and testbench
================================

Name: seq_mult_ctrl

Overview:
- FSM controller for the shift-add sequential multiplier datapath.
- Accepts a start request and sequences the operand registers, the accumulator and the addend-select 2:1 mux (mux output = 0 or multiplicand).
- Drives the shift registers, counts one ADD/SHIFT pair per multiplier bit, and holds a done/ack handshake to the consumer.
- Sits between the top-level requester and the multiplier datapath; contains no data path itself.

Parameters:
- WIDTH, 8, operand width in bits = number of ADD/SHIFT iterations; legal range 1..255.
- COUNT_WIDTH, 4, width of the iteration counter; must satisfy 2^COUNT_WIDTH > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiply; sampled only when ready=1.
- result_ack  input  1  consumer has taken the product; sampled only when done=1.
- b_lsb  input  1  current LSB of the multiplier shift register, from the datapath.
- ready  output  1  controller idle, start will be accepted.
- busy  output  1  multiply in progress (states LOAD, ADD, SHIFT).
- done  output  1  product valid on datapath outputs; held until acked.
- load_ab  output  1  load multiplicand/multiplier registers from operand inputs.
- clear_acc  output  1  synchronous clear of accumulator.
- add_sel  output  1  address of the addend 2:1 mux: 1 = multiplicand, 0 = zero.
- acc_en  output  1  accumulator captures accumulator + mux output.
- shift_en  output  1  multiplicand shifts left 1, multiplier shifts right 1.
- count  output  COUNT_WIDTH  remaining iterations (debug/visibility).

Behaviour:
- States: IDLE, LOAD, ADD, SHIFT, DONE. State register is clocked; all outputs are decoded from state, except add_sel, which is combinational from b_lsb.
- Reset (reset=1 at a rising edge): state=IDLE, count=0.
  - Outputs after reset: ready=1; busy, done, load_ab, clear_acc, add_sel, acc_en, shift_en all 0.
  - Reset takes priority over every other input in every state. Reset mid-operation abandons the multiply; no done is produced.
- IDLE:
  - ready=1.
  - start=1 -> LOAD. Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - load_ab=1, clear_acc=1, busy=1.
  - count <= WIDTH.
  - Next state: ADD.
- ADD (1 cycle):
  - busy=1, acc_en=1, add_sel=b_lsb.
  - Next state: SHIFT.
- SHIFT (1 cycle):
  - busy=1, shift_en=1, count <= count-1.
  - count==1 at entry -> DONE; else -> ADD.
- DONE:
  - done=1; ready=0, busy=0.
  - count holds 0; the datapath holds the product because no enables are asserted.
  - result_ack=1 -> IDLE; else stay. done never drops without ack.
- add_sel=0 in every state other than ADD. At most one of load_ab, acc_en, shift_en is high in any cycle.
- Latency and throughput:
  - Start accepted at edge E0 -> done first high in the cycle following edge E0+1+2*WIDTH (18 cycles for WIDTH=8).
  - Minimum period between starts is 3+2*WIDTH cycles.
- Boundary conditions:
  - start while busy or done is ignored; it is not queued.
  - start and result_ack both high in DONE: ack is taken, start is ignored; ready rises the next cycle.
  - result_ack outside DONE is ignored.
  - WIDTH=1: exactly one ADD/SHIFT pair.
  - b_lsb is only meaningful in ADD; its value elsewhere has no effect.

Test Plan:
- Reset, then idle with no stimulus -> ready=1, all other outputs 0, count=0 for 10 cycles.
- WIDTH=8, start=1 for one cycle, datapath model with multiplicand=3, multiplier=5 -> one load_ab cycle, then 8 ADD/SHIFT pairs with add_sel sequence 1,0,1,0,0,0,0,0. done rises 18 cycles after acceptance; model product=15; count goes 8..0.
- Hold result_ack=0 for 20 cycles in DONE -> done stays 1 and no enables pulse; ack=1 -> ready=1 next cycle.
- Pulse start during SHIFT of iteration 3 and again in DONE -> ignored; sequence and total latency unchanged; no second LOAD.
- Assert reset in ADD of iteration 4 -> next cycle IDLE, ready=1, done never asserted; a new start then runs a full 8-iteration sequence.
- Back-to-back: ack and start together in DONE -> IDLE for one cycle; a start in that cycle reaches LOAD after one more edge; period = 19 cycles.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// Controller for a shift-add sequential multiplier. It sequences load, accumulate and
// shift enables for an external datapath and holds a done/ack handshake with the consumer.
module seq_mult_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   result_ack,
  input  logic                   b_lsb,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   load_ab,
  output logic                   clear_acc,
  output logic                   add_sel,
  output logic                   acc_en,
  output logic                   shift_en,
  output logic [COUNT_WIDTH-1:0] count
);

  // The counter must be able to hold WIDTH itself, and at least one iteration must run.
  if (WIDTH < 1 || WIDTH > 255 || (64'd1 << COUNT_WIDTH) <= 64'(WIDTH)) begin : gen_param_check
    $error("seq_mult_ctrl: WIDTH must be 1..255 and fit in COUNT_WIDTH bits");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAdd,
    StShift,
    StDone
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CountInit = COUNT_WIDTH'(WIDTH);
  localparam logic [COUNT_WIDTH-1:0] CountOne  = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        count_d = CountInit;
        state_d = StAdd;
      end
      StAdd: begin
        state_d = StShift;
      end
      StShift: begin
        count_d = count_q - CountOne;
        // The count is checked before the decrement, so 1 here means the last pair just ran.
        state_d = (count_q == CountOne) ? StDone : StAdd;
      end
      StDone: begin
        if (result_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load_ab   = 1'b0;
    clear_acc = 1'b0;
    add_sel   = 1'b0;
    acc_en    = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
      end
      StLoad: begin
        busy      = 1'b1;
        load_ab   = 1'b1;
        clear_acc = 1'b1;
      end
      StAdd: begin
        busy    = 1'b1;
        acc_en  = 1'b1;
        add_sel = b_lsb;
      end
      StShift: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl with a small shift-add datapath model driven by its enables.
module tb_seq_mult_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, result_ack, b_lsb;
  logic       ready, busy, done, load_ab, clear_acc, add_sel, acc_en, shift_en;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  op_a, op_b, mp;
  logic [15:0] mc, acc;
  logic [7:0]  ov;

  seq_mult_ctrl #(.WIDTH(8), .COUNT_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .result_ack(result_ack),
    .b_lsb     (b_lsb),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .load_ab   (load_ab),
    .clear_acc (clear_acc),
    .add_sel   (add_sel),
    .acc_en    (acc_en),
    .shift_en  (shift_en),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Datapath model: multiplicand shifts left, multiplier shifts right, accumulator adds.
  always @(posedge clk) begin
    if (reset) begin
      mc  <= '0;
      mp  <= '0;
      acc <= '0;
    end else begin
      if (load_ab) begin
        mc <= {8'd0, op_a};
        mp <= op_b;
      end
      if (clear_acc) acc <= '0;
      if (acc_en) acc <= acc + (add_sel ? mc : 16'd0);
      if (shift_en) begin
        mc <= mc << 1;
        mp <= mp >> 1;
      end
    end
  end

  assign b_lsb = mp[0];
  assign ov    = {ready, busy, done, load_ab, clear_acc, add_sel, acc_en, shift_en};

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] b, output int accept);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    step();
    start  = 1'b0;
    accept = cyc;
    chk("load_outputs", {24'd0, ov}, 32'h58);
  endtask

  // Runs from LOAD until DONE or a cycle budget, recording enables and the add_sel sequence.
  task automatic run_to_done(input bit poke, input bit ack_busy, output int edges,
                             output int loads, output int adds, output int shifts,
                             output logic [7:0] sel, output int ovl);
    edges = 0; loads = 0; adds = 0; shifts = 0; sel = '0; ovl = 0;
    while (!done && edges < 60) begin
      if (load_ab) loads++;
      if (acc_en) begin
        chk("add_count", {28'd0, count}, 32'(8 - adds));
        if (adds < 8) sel[adds] = add_sel;
        adds++;
      end
      if (shift_en) shifts++;
      if (int'(load_ab) + int'(acc_en) + int'(shift_en) > 1) ovl++;
      start      = poke && shift_en && (shifts == 3);
      result_ack = ack_busy && busy;
      step();
      edges++;
    end
    start      = 1'b0;
    result_ack = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [15:0] product, input logic [7:0] sel_exp,
                           input bit poke, input bit ack_busy);
    int edges, loads, adds, shifts, ovl;
    logic [7:0] sel;
    run_to_done(poke, ack_busy, edges, loads, adds, shifts, sel, ovl);
    chk({tag, "_latency"}, 32'(edges + 1), 32'd18);
    chk({tag, "_loads"}, 32'(loads), 32'd1);
    chk({tag, "_adds"}, 32'(adds), 32'd8);
    chk({tag, "_shifts"}, 32'(shifts), 32'd8);
    chk({tag, "_add_sel_seq"}, {24'd0, sel}, {24'd0, sel_exp});
    chk({tag, "_onehot"}, 32'(ovl), 32'd0);
    chk({tag, "_done_outputs"}, {24'd0, ov}, 32'h20);
    chk({tag, "_done_count"}, {28'd0, count}, 32'd0);
    chk({tag, "_product"}, {16'd0, acc}, {16'd0, product});
  endtask

  initial begin
    int accept1, accept2, found;
    reset = 1'b1; start = 1'b0; result_ack = 1'b0; op_a = '0; op_b = '0;
    step();
    step();
    reset = 1'b0;

    // Idle with no stimulus; a stray ack must be ignored.
    for (int i = 0; i < 10; i++) begin
      chk("idle_outputs", {24'd0, ov}, 32'h80);
      chk("idle_count", {28'd0, count}, 32'd0);
      result_ack = (i == 4);
      step();
    end
    result_ack = 1'b0;

    // 3 * 5 with a start pulse in the third SHIFT and acks while busy.
    do_start(8'd3, 8'd5, accept1);
    check_run("mul3x5", 16'd15, 8'b0000_0101, 1'b1, 1'b1);

    // DONE holds without ack; a start pulse here is ignored.
    for (int i = 0; i < 20; i++) begin
      chk("done_hold", {24'd0, ov}, 32'h20);
      start = (i == 5);
      step();
    end
    start      = 1'b0;
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    chk("after_ack_idle", {24'd0, ov}, 32'h80);

    // Reset during the fourth ADD abandons the multiply.
    do_start(8'd3, 8'd5, accept1);
    found = 0;
    for (int i = 0; i < 40 && found < 4; i++) begin
      step();
      if (acc_en) found++;
    end
    chk("abort_reached_add4", 32'(found), 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_idle", {24'd0, ov}, 32'h80);
    chk("abort_count", {28'd0, count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end

    // Fresh run after the abort, then back-to-back with ack and start together.
    do_start(8'd13, 8'd11, accept1);
    check_run("mul13x11", 16'd143, 8'b0000_1011, 1'b0, 1'b0);
    op_a       = 8'd255;
    op_b       = 8'd255;
    result_ack = 1'b1;
    start      = 1'b1;
    step();
    result_ack = 1'b0;
    chk("b2b_idle", {24'd0, ov}, 32'h80);
    step();
    start   = 1'b0;
    accept2 = cyc;
    chk("b2b_load", {24'd0, ov}, 32'h58);
    chk("b2b_period", 32'(accept2 - accept1), 32'd19);
    check_run("mul255x255", 16'd65025, 8'hff, 1'b0, 1'b0);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    chk("final_idle", {24'd0, ov}, 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
